// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: handshake, data and status bundle for sync_fifo_param.
// The master modport is the user side of the queue; the slave modport is the
// FIFO side. The clock and reset stay as plain ports on the FIFO itself.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
);
    logic                  we;
    logic                  re;
    logic                  flush;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty_bar;
    logic                  full_bar;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   fillcount;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output we, re, flush, clr_err, data_in,
        input  data_out, empty_bar, full_bar, almost_full, almost_empty,
               fillcount, overflow, underflow
    );

    modport slave (
        input  we, re, flush, clr_err, data_in,
        output data_out, empty_bar, full_bar, almost_full, almost_empty,
               fillcount, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with a generic width and depth,
// almost-full/almost-empty thresholds, a same-cycle read+write at full,
// a synchronous flush and sticky overflow/underflow flags.
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through
// reads (data_out shows the head word combinationally). When the macro is not
// defined, reads are registered with a latency of one clock.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int AF_THRESH  = 28,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sync_fifo_param_if.slave      bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = ADDR_WIDTH + 1;

    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

    // Storage is deliberately left out of reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The extra MSB on each pointer is the wrap bit that tells full from empty.
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      fill;

    logic                  empty;
    logic                  full;
    logic                  renq_raw;
    logic                  wenq_raw;
    logic                  renq;
    logic                  wenq;
    logic                  ovf_set;
    logic                  unf_set;
    logic                  overflow_r;
    logic                  underflow_r;

    // Status is decoded purely from the registered pointers.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign fill  = wr_ptr - rd_ptr;

    // A read frees a slot in the same cycle, so a write at full is accepted
    // when it is paired with an accepted read. At empty the read loses.
    assign renq_raw = bus.re & ~empty;
    assign wenq_raw = bus.we & (~full | renq_raw);

    // A flush cycle masks every request and every error condition.
    assign renq    = renq_raw & ~bus.flush;
    assign wenq    = wenq_raw & ~bus.flush;
    assign ovf_set = bus.we & ~wenq_raw & ~bus.flush;
    assign unf_set = bus.re & ~renq_raw & ~bus.flush;

    // Pointer update: flush drops everything stored by catching rd up to wr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (wenq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (renq) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage write on every accepted write.
    always_ff @(posedge clk) begin
        if (wenq) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
    end

    // Sticky error flags: a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (!bus.flush) begin
            if (ovf_set)          overflow_r  <= 1'b1;
            else if (bus.clr_err) overflow_r  <= 1'b0;
            if (unf_set)          underflow_r <= 1'b1;
            else if (bus.clr_err) underflow_r <= 1'b0;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown directly; it is only meaningful while not empty.
    assign bus.data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];
`else
    logic [DATA_WIDTH-1:0] data_out_p1;

    // Registered read: the word leaves storage one clock after the request
    // and is held until the next accepted read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_p1 <= '0;
        end else if (renq) begin
            data_out_p1 <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    assign bus.data_out = data_out_p1;
`endif

    assign bus.empty_bar    = ~empty;
    assign bus.full_bar     = ~full;
    assign bus.fillcount    = fill;
    assign bus.almost_full  = (fill >= AF_LVL);
    assign bus.almost_empty = (fill <= AE_LVL);
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: vector table of requests with expected status per edge,
// plus a data scoreboard queue filled on accepted writes and drained on
// accepted reads. Build with +define+SYNC_FIFO_FWFT_EN for the FWFT variant.
module tb_sync_fifo_param;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic        flush;
        logic        clr;
        logic [15:0] din;
        int          fill;
        logic        eb;
        logic        fb;
        logic        af;
        logic        ae;
        logic        ovf;
        logic        unf;
    } vec_t;

    logic clk;
    logic reset_n;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(6), .AE_THRESH(1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    vec_t        vecs[$];
    logic [15:0] sb[$];
    logic [15:0] exp_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic we, input logic re,
                       input logic flush, input logic clr, input logic [15:0] din,
                       input int fill, input logic eb, input logic fb,
                       input logic af, input logic ae, input logic ovf, input logic unf);
        vec_t v;
        v.name = name; v.we = we; v.re = re; v.flush = flush; v.clr = clr;
        v.din = din; v.fill = fill; v.eb = eb; v.fb = fb; v.af = af; v.ae = ae;
        v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    task automatic check_status(input string name, input int fill, input logic eb,
                                input logic fb, input logic af, input logic ae,
                                input logic ovf, input logic unf);
        check({name, ".fillcount"}, 32'(bus.fillcount), 32'(fill));
        check({name, ".empty_bar"}, 32'(bus.empty_bar), 32'(eb));
        check({name, ".full_bar"}, 32'(bus.full_bar), 32'(fb));
        check({name, ".almost_full"}, 32'(bus.almost_full), 32'(af));
        check({name, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
        check({name, ".overflow"}, 32'(bus.overflow), 32'(ovf));
        check({name, ".underflow"}, 32'(bus.underflow), 32'(unf));
    endtask

    // Drive one vector, update the scoreboard from the request pattern, and
    // check status and data one time unit after the edge.
    task automatic apply(input vec_t v);
        logic rd_ok;
        logic wr_ok;
        @(negedge clk);
        bus.we = v.we; bus.re = v.re; bus.flush = v.flush;
        bus.clr_err = v.clr; bus.data_in = v.din;
        rd_ok = v.re && (sb.size() > 0) && !v.flush;
        wr_ok = v.we && ((sb.size() < DEPTH) || rd_ok) && !v.flush;
        if (v.flush) sb.delete();
        else begin
            if (rd_ok) exp_dout = sb.pop_front();
            if (wr_ok) sb.push_back(v.din);
        end
        @(posedge clk);
        #1;
        check_status(v.name, v.fill, v.eb, v.fb, v.af, v.ae, v.ovf, v.unf);
`ifdef SYNC_FIFO_FWFT_EN
        if (sb.size() > 0) check({v.name, ".data_out"}, 32'(bus.data_out), 32'(sb[0]));
`else
        check({v.name, ".data_out"}, 32'(bus.data_out), 32'(exp_dout));
`endif
        bus.we = 1'b0; bus.re = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    endtask

    initial begin
        vec_t v;
        //   name      we re fl clr din     fill eb fb af ae ovf unf
        add("wr1",     1, 0, 0, 0, 16'h0001, 1, 1, 1, 0, 1, 0, 0);
        add("wr2",     1, 0, 0, 0, 16'h0002, 2, 1, 1, 0, 0, 0, 0);
        add("wr3",     1, 0, 0, 0, 16'h0003, 3, 1, 1, 0, 0, 0, 0);
        add("wr4",     1, 0, 0, 0, 16'h0004, 4, 1, 1, 0, 0, 0, 0);
        add("wr5",     1, 0, 0, 0, 16'h0005, 5, 1, 1, 0, 0, 0, 0);
        add("wr6",     1, 0, 0, 0, 16'h0006, 6, 1, 1, 1, 0, 0, 0);
        add("wr7",     1, 0, 0, 0, 16'h0007, 7, 1, 1, 1, 0, 0, 0);
        add("wr8",     1, 0, 0, 0, 16'h0008, 8, 1, 0, 1, 0, 0, 0);
        add("wr9ovf",  1, 0, 0, 0, 16'h00EE, 8, 1, 0, 1, 0, 1, 0);
        add("rwfull",  1, 1, 0, 0, 16'h0009, 8, 1, 0, 1, 0, 1, 0);
        add("clrovf",  0, 0, 0, 1, 16'h0000, 8, 1, 0, 1, 0, 0, 0);
        add("rd7",     0, 1, 0, 0, 16'h0000, 7, 1, 1, 1, 0, 0, 0);
        add("rd6",     0, 1, 0, 0, 16'h0000, 6, 1, 1, 1, 0, 0, 0);
        add("rd5",     0, 1, 0, 0, 16'h0000, 5, 1, 1, 0, 0, 0, 0);
        add("rd4",     0, 1, 0, 0, 16'h0000, 4, 1, 1, 0, 0, 0, 0);
        add("rd3",     0, 1, 0, 0, 16'h0000, 3, 1, 1, 0, 0, 0, 0);
        add("rd2",     0, 1, 0, 0, 16'h0000, 2, 1, 1, 0, 0, 0, 0);
        add("rd1",     0, 1, 0, 0, 16'h0000, 1, 1, 1, 0, 1, 0, 0);
        add("rd0",     0, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 0, 0);
        add("rdempty", 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 0, 1);
        add("clrunf",  0, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 0, 0);
        add("rwempty", 1, 1, 0, 0, 16'h000A, 1, 1, 1, 0, 1, 0, 1);
        add("clr_rd",  0, 1, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 0, 0);
        add("setwins", 0, 1, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 0, 1);
        add("clrunf2", 0, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 0, 0);
        add("ld1",     1, 0, 0, 0, 16'h0010, 1, 1, 1, 0, 1, 0, 0);
        add("ld2",     1, 0, 0, 0, 16'h0011, 2, 1, 1, 0, 0, 0, 0);
        add("ld3",     1, 0, 0, 0, 16'h0012, 3, 1, 1, 0, 0, 0, 0);
        add("ld4",     1, 0, 0, 0, 16'h0013, 4, 1, 1, 0, 0, 0, 0);
        add("ld5",     1, 0, 0, 0, 16'h0014, 5, 1, 1, 0, 0, 0, 0);
        add("flushwr", 1, 1, 1, 0, 16'h0015, 0, 0, 1, 0, 1, 0, 0);
        add("postfl",  0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 0, 0);

        bus.we = 1'b0; bus.re = 1'b0; bus.flush = 1'b0;
        bus.clr_err = 1'b0; bus.data_in = '0;
        exp_dout = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 0, 0, 1, 0, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("reset.data_out", 32'(bus.data_out), 32'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Write/read pairs that carry both pointers around the ring twice.
        for (int i = 0; i < 20; i++) begin
            add($sformatf("wrap_w%0d", i), 1, 0, 0, 0, 16'(16'h0100 + i), 1, 1, 1, 0, 1, 0, 0);
            v = vecs[$];
            apply(v);
            add($sformatf("wrap_r%0d", i), 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 0, 0);
            v = vecs[$];
            apply(v);
        end

`ifdef SYNC_FIFO_FWFT_EN
        // Fall-through: a word written to an empty FIFO shows up with no read.
        add("fwft_wr", 1, 0, 0, 0, 16'h00AA, 1, 1, 1, 0, 1, 0, 0);
        v = vecs[$];
        apply(v);
        check("fwft_show", 32'(bus.data_out), 32'h00AA);
        add("fwft_rd", 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 0, 0);
        v = vecs[$];
        apply(v);
`endif

        // Build up state, then drop reset between clock edges.
        add("pre_unf", 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 0, 1);
        v = vecs[$];
        apply(v);
        for (int i = 0; i < 3; i++) begin
            add($sformatf("burst%0d", i), 1, 0, 0, 0, 16'(16'h0200 + i), i + 1, 1, 1, 0, (i == 0), 0, 1);
            v = vecs[$];
            apply(v);
        end
        @(negedge clk);
        bus.we = 1'b1; bus.re = 1'b1; bus.data_in = 16'h0BAD;
        #2;
        reset_n = 1'b0;
        #1;
        check_status("async_rst", 0, 0, 1, 0, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("async_rst.data_out", 32'(bus.data_out), 32'h0);
`endif
        bus.we = 1'b0; bus.re = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
